quicksort_ctrl: RTL and testbench

//  Sequencer for the Lomuto partition datapath: runs a full quicksort over an ARR_WIDTH-element array.

---
 rtl/quicksort_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_quicksort_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/quicksort_ctrl.sv
// quicksort_ctrl: sequencer that runs a full quicksort by driving a Lomuto
// partition unit one (lo,hi) job at a time from an explicit range stack.
// Optional build macro QSORT_STATS_EN adds part_count_o and stack_hwm_o.
module quicksort_ctrl #(
    parameter int ARR_WIDTH   = 4,
    parameter int IDX_W       = 2,
    parameter int STACK_DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             error_o,
    output logic             part_start_o,
    output logic [IDX_W-1:0] part_lo_o,
    output logic [IDX_W-1:0] part_hi_o,
    input  logic             part_done_i,
    input  logic [IDX_W-1:0] part_pivot_idx_i
`ifdef QSORT_STATS_EN
    ,
    output logic [IDX_W+3:0]                   part_count_o,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_hwm_o
`endif
);
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int SPX   = SP_W + 1;
    localparam int IDXX  = IDX_W + 1;
    localparam int SLOTS = 1 << SP_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ARR_WIDTH - 1);
    localparam logic [SPX-1:0]   DEPTH_X  = SPX'(STACK_DEPTH);
    localparam logic [IDXX-1:0]  ONE_X    = IDXX'(1);
    localparam logic [IDXX-1:0]  TWO_X    = IDXX'(2);
    localparam logic [SP_W-1:0]  SP_ONE   = SP_W'(1);

    typedef enum logic [2:0] {S_IDLE, S_POP, S_ISSUE, S_WAIT, S_PUSH, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic [IDX_W-1:0]  lo_q, lo_d, hi_q, hi_d, piv_q, piv_d;
    logic              busy_q, busy_d, done_q, done_d, err_q, err_d, pstart_q, pstart_d;

    // Range stack storage; slots beyond STACK_DEPTH are never addressed.
    logic [IDX_W-1:0]  stk_lo [SLOTS];
    logic [IDX_W-1:0]  stk_hi [SLOTS];
    logic              wr0_en, wr1_en;
    logic [SP_W-1:0]   wr0_idx, wr1_idx;
    logic [IDX_W-1:0]  wr0_lo, wr0_hi, wr1_lo, wr1_hi;

    // Widened index arithmetic so p+1 / p-1 never wrap at the array ends.
    logic [IDXX-1:0]   lo_x, hi_x, p_x, right_len, left_len, p_inc, p_dec;
    logic              need_r, need_l;
    logic [SPX-1:0]    n_push, free_x;
    logic [SP_W-1:0]   top_idx;

    assign lo_x      = {1'b0, lo_q};
    assign hi_x      = {1'b0, hi_q};
    assign p_x       = {1'b0, piv_q};
    assign right_len = hi_x - p_x;
    assign left_len  = p_x - lo_x;
    assign p_inc     = p_x + ONE_X;
    assign p_dec     = p_x - ONE_X;
    assign need_r    = (right_len >= TWO_X);
    assign need_l    = (left_len >= TWO_X);
    assign n_push    = SPX'(need_r) + SPX'(need_l);
    assign free_x    = DEPTH_X - {1'b0, sp_q};
    assign top_idx   = sp_q - SP_ONE;

    // State, registered outputs and stack pointer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            sp_q     <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            piv_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            pstart_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sp_q     <= sp_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            piv_q    <= piv_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            pstart_q <= pstart_d;
        end
    end

    // Stack write port; contents need no reset because sp_q gates validity.
    always_ff @(posedge clk_i) begin
        if (wr0_en) begin
            stk_lo[wr0_idx] <= wr0_lo;
            stk_hi[wr0_idx] <= wr0_hi;
        end
        if (wr1_en) begin
            stk_lo[wr1_idx] <= wr1_lo;
            stk_hi[wr1_idx] <= wr1_hi;
        end
    end

    // Next-state logic: done_d/pstart_d are set on entry so they show for one cycle.
    always_comb begin
        state_d  = state_q;
        sp_d     = sp_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        piv_d    = piv_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        pstart_d = 1'b0;
        wr0_en   = 1'b0;
        wr0_idx  = sp_q;
        wr0_lo   = '0;
        wr0_hi   = '0;
        wr1_en   = 1'b0;
        wr1_idx  = sp_q + SP_ONE;
        wr1_lo   = '0;
        wr1_hi   = '0;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    err_d  = 1'b0;
                    busy_d = 1'b1;
                    if (ARR_WIDTH == 1) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        wr0_en  = 1'b1;
                        wr0_idx = '0;
                        wr0_lo  = '0;
                        wr0_hi  = LAST_IDX;
                        sp_d    = SP_ONE;
                        state_d = S_POP;
                    end
                end
            end
            S_POP: begin
                if (sp_q == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    sp_d    = top_idx;
                    lo_d    = stk_lo[top_idx];
                    hi_d    = stk_hi[top_idx];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                pstart_d = 1'b1;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (part_done_i) begin
                    piv_d = part_pivot_idx_i;
                    if (part_pivot_idx_i < lo_q || part_pivot_idx_i > hi_q) begin
                        err_d   = 1'b1;
                        sp_d    = '0;
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_PUSH;
                    end
                end
            end
            S_PUSH: begin
                if (n_push > free_x) begin
                    err_d   = 1'b1;
                    sp_d    = '0;
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    // Right range goes below left so the left range pops first.
                    if (need_r) begin
                        wr0_en = 1'b1;
                        wr0_lo = p_inc[IDX_W-1:0];
                        wr0_hi = hi_q;
                        if (need_l) begin
                            wr1_en = 1'b1;
                            wr1_lo = lo_q;
                            wr1_hi = p_dec[IDX_W-1:0];
                        end
                    end else if (need_l) begin
                        wr0_en = 1'b1;
                        wr0_lo = lo_q;
                        wr0_hi = p_dec[IDX_W-1:0];
                    end
                    sp_d    = sp_q + n_push[SP_W-1:0];
                    state_d = S_POP;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign error_o      = err_q;
    assign part_start_o = pstart_q;
    assign part_lo_o    = lo_q;
    assign part_hi_o    = hi_q;

`ifdef QSORT_STATS_EN
    localparam logic [IDX_W+3:0] CNT_ONE = (IDX_W+4)'(1);
    logic [IDX_W+3:0] cnt_q;
    logic [SP_W-1:0]  hwm_q;

    // Per-sort job count (saturating) and peak stack occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            hwm_q <= '0;
        end else if (state_q == S_IDLE && start_i) begin
            cnt_q <= '0;
            hwm_q <= sp_d;
        end else begin
            if (state_q == S_ISSUE && cnt_q != '1) cnt_q <= cnt_q + CNT_ONE;
            if (sp_d > hwm_q) hwm_q <= sp_d;
        end
    end

    assign part_count_o = cnt_q;
    assign stack_hwm_o  = hwm_q;
`endif
endmodule

// File: tb/tb_quicksort_ctrl.sv
// tb_quicksort_ctrl: directed scoreboard bench for quicksort_ctrl (4 elements,
// 4-deep stack). Stimulus queues expected jobs/done flags; a monitor checks them.
module tb_quicksort_ctrl;
    localparam int AW = 4;
    localparam int IW = 2;
    localparam int SD = 4;

    logic clk = 1'b0;
    logic rst_ni, start_i, part_done_i;
    logic [IW-1:0] part_pivot_idx_i;
    logic busy_o, done_o, error_o, part_start_o;
    logic [IW-1:0] part_lo_o, part_hi_o;
`ifdef QSORT_STATS_EN
    logic [IW+3:0] part_count_o;
    logic [2:0]    stack_hwm_o;
`endif

    int tests = 0;
    int fails = 0;
    logic [2*IW-1:0] exp_job [$];
    logic            exp_err [$];
    logic [IW-1:0]   piv_q   [$];

    always #5 clk = ~clk;

    quicksort_ctrl #(.ARR_WIDTH(AW), .IDX_W(IW), .STACK_DEPTH(SD)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .start_i          (start_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .error_o          (error_o),
        .part_start_o     (part_start_o),
        .part_lo_o        (part_lo_o),
        .part_hi_o        (part_hi_o),
        .part_done_i      (part_done_i),
        .part_pivot_idx_i (part_pivot_idx_i)
`ifdef QSORT_STATS_EN
        ,
        .part_count_o     (part_count_o),
        .stack_hwm_o      (stack_hwm_o)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add_job(input int lo, input int hi);
        exp_job.push_back({IW'(lo), IW'(hi)});
    endtask

    // Monitor: every job strobe and done pulse is matched against the queues.
    initial begin
        logic [2*IW-1:0] e;
        logic            ee;
        forever begin
            @(negedge clk);
            if (rst_ni) begin
                if (part_start_o) begin
                    $display("[TB] job lo=%0d hi=%0d", part_lo_o, part_hi_o);
                    if (exp_job.size() == 0) begin
                        check("unexpected_job", part_start_o, 0);
                    end else begin
                        e = exp_job.pop_front();
                        check("job_lo", part_lo_o, e[2*IW-1:IW]);
                        check("job_hi", part_hi_o, e[IW-1:0]);
                    end
                end
                if (done_o) begin
                    $display("[TB] done error=%0d", error_o);
                    if (exp_err.size() == 0) begin
                        check("unexpected_done", done_o, 0);
                    end else begin
                        ee = exp_err.pop_front();
                        check("done_error", error_o, ee);
                    end
                end
            end
        end
    end

    // Partition unit model: answers each job with the next queued pivot.
    initial begin
        part_done_i      = 1'b0;
        part_pivot_idx_i = '0;
        forever begin
            @(negedge clk);
            if (rst_ni && part_start_o && piv_q.size() > 0) begin
                part_pivot_idx_i = piv_q.pop_front();
                @(negedge clk);
                part_done_i = 1'b1;
                @(negedge clk);
                part_done_i = 1'b0;
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check("busy_after_start", busy_o, 1);
        check("error_cleared", error_o, 0);
    endtask

    task automatic wait_done(input int budget, input bit chk_jobs);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done_o) seen = 1'b1;
        end
        check("done_seen", seen, 1);
        if (seen) begin
            @(negedge clk);
            check("busy_after_done", busy_o, 0);
            check("done_one_cycle", done_o, 0);
            if (chk_jobs) check("jobs_left", exp_job.size(), 0);
        end
    endtask

    task automatic wait_job(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (part_start_o) seen = 1'b1;
        end
        check("job_seen", seen, 1);
    endtask

    initial begin
        bit ok;
        int cnt;
        rst_ni  = 1'b0;
        start_i = 1'b0;
        #3;
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_error", error_o, 0);
        check("rst_part_start", part_start_o, 0);
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;

        // 1: reset asserted while waiting for a partition result
        add_job(0, 3);
        pulse_start();
        wait_job(10, ok);
        #2 rst_ni = 1'b0;
        #1;
        check("midrst_busy", busy_o, 0);
        check("midrst_part_start", part_start_o, 0);
        check("midrst_part_lo", part_lo_o, 0);
        check("midrst_part_hi", part_hi_o, 0);
        check("midrst_done", done_o, 0);
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (part_start_o) cnt++;
        end
        check("no_job_after_reset", cnt, 0);
        check("jobs_left_reset", exp_job.size(), 0);

        // 2: pivot 3 then 1, with start-to-strobe latency
        add_job(0, 3); add_job(0, 2);
        piv_q.push_back(2'd3); piv_q.push_back(2'd1);
        exp_err.push_back(1'b0);
        pulse_start();
        @(negedge clk);
        check("latency_early", part_start_o, 0);
        @(negedge clk);
        check("latency_two_cycles", part_start_o, 1);
        wait_done(100, 1);
`ifdef QSORT_STATS_EN
        check("part_count_t2", part_count_o, 2);
        check("stack_hwm_t2", stack_hwm_o, 1);
`endif

        // 3: pivot 1 pushes only the right range
        add_job(0, 3); add_job(2, 3);
        piv_q.push_back(2'd1); piv_q.push_back(2'd2);
        exp_err.push_back(1'b0);
        pulse_start();
        wait_done(100, 1);

        // 4: pivots 0,1,2 walk the right edge
        add_job(0, 3); add_job(1, 3); add_job(2, 3);
        piv_q.push_back(2'd0); piv_q.push_back(2'd1); piv_q.push_back(2'd2);
        exp_err.push_back(1'b0);
        pulse_start();
        wait_done(100, 1);
        check("error_t4", error_o, 0);
`ifdef QSORT_STATS_EN
        check("part_count_t4", part_count_o, 3);
`endif

        // 5: out-of-range pivot aborts with error; next start clears it
        add_job(0, 3); add_job(0, 2);
        piv_q.push_back(2'd3); piv_q.push_back(2'd3);
        exp_err.push_back(1'b1);
        pulse_start();
        wait_done(100, 1);
        check("error_sticky", error_o, 1);
        add_job(0, 3); add_job(2, 3);
        piv_q.push_back(2'd1); piv_q.push_back(2'd2);
        exp_err.push_back(1'b0);
        pulse_start();
        wait_done(100, 1);

        // 6: start held high: one sort, then a second once IDLE is re-entered
        add_job(0, 3); add_job(0, 2);
        add_job(0, 3); add_job(1, 3); add_job(2, 3);
        piv_q.push_back(2'd3); piv_q.push_back(2'd1);
        piv_q.push_back(2'd0); piv_q.push_back(2'd1); piv_q.push_back(2'd2);
        exp_err.push_back(1'b0); exp_err.push_back(1'b0);
        @(negedge clk);
        start_i = 1'b1;
        wait_done(100, 0);
        check("jobs_after_first_held", exp_job.size(), 3);
        wait_job(20, ok);
        start_i = 1'b0;
        wait_done(100, 1);
        repeat (5) @(negedge clk);
        check("idle_after_held", busy_o, 0);
        check("dones_left", exp_err.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
